// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encodings, arbiter FSM state type and datapath width
// shared by the ALU and the two-requester ALU arbiter.
package alu_pkg;
    localparam int DATA_W = 32;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SRA  = 4'b1101
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit integer ALU; unknown op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    input  logic [3:0]        i_alu_op,
    output logic [DATA_W-1:0] o_alu_data
);
    logic [4:0] sh;
    assign sh = i_op_b[4:0];
    always_comb begin
        case (i_alu_op)
            ALU_ADD:  o_alu_data = i_op_a + i_op_b;
            ALU_SUB:  o_alu_data = i_op_a - i_op_b;
            ALU_SLL:  o_alu_data = i_op_a << sh;
            ALU_SLT:  o_alu_data = {{(DATA_W-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
            ALU_SLTU: o_alu_data = {{(DATA_W-1){1'b0}}, i_op_a < i_op_b};
            ALU_XOR:  o_alu_data = i_op_a ^ i_op_b;
            ALU_SRL:  o_alu_data = i_op_a >> sh;
            ALU_OR:   o_alu_data = i_op_a | i_op_b;
            ALU_AND:  o_alu_data = i_op_a & i_op_b;
            ALU_SRA:  o_alu_data = $signed(i_op_a) >>> sh;
            default:  o_alu_data = '0;
        endcase
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one ALU, one op in flight (IDLE->EXEC->RESP).
// Round-robin tie-break by default; ALU_ARB_FIXED_PRIO_EN makes requester 0 always win.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0_valid,
    input  logic              i_req1_valid,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req0_op_a,
    input  logic [DATA_W-1:0] i_req0_op_b,
    input  logic [DATA_W-1:0] i_req1_op_a,
    input  logic [DATA_W-1:0] i_req1_op_b,
    input  logic [3:0]        i_req0_alu_op,
    input  logic [3:0]        i_req1_alu_op,
    output logic              o_rsp0_valid,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp0_data,
    output logic [DATA_W-1:0] o_rsp1_data,
    input  logic              i_rsp0_ready,
    input  logic              i_rsp1_ready,
    output logic [CNT_W-1:0]  o_grant_cnt0,
    output logic [CNT_W-1:0]  o_grant_cnt1
);
    state_e            state, state_nx;
    logic [DATA_W-1:0] lat_a, lat_b, res, alu_data;
    logic [3:0]        lat_op;
    logic              lat_id, sel, accept, done;

    alu u_alu (
        .i_op_a    (lat_a),
        .i_op_b    (lat_b),
        .i_alu_op  (lat_op),
        .o_alu_data(alu_data)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign sel = ~i_req0_valid;
`else
    logic ptr;
    assign sel = (i_req0_valid && i_req1_valid) ? ptr : i_req1_valid;
    // Pointer hands the next tie to whoever was not just served.
    always_ff @(posedge i_clk) begin
        if (!i_reset) ptr <= 1'b0;
        else if (done) ptr <= ~lat_id;
    end
`endif

    always_comb begin
        o_req0_ready = i_reset && state == IDLE && i_req0_valid && !sel;
        o_req1_ready = i_reset && state == IDLE && i_req1_valid && sel;
        accept       = o_req0_ready || o_req1_ready;
        done         = state == RESP && (lat_id ? i_rsp1_ready : i_rsp0_ready);
        o_rsp0_valid = state == RESP && !lat_id;
        o_rsp1_valid = state == RESP && lat_id;
        o_rsp0_data  = o_rsp0_valid ? res : '0;
        o_rsp1_data  = o_rsp1_valid ? res : '0;
        state_nx     = state;
        state_nx     = (state == IDLE) ? (accept ? EXEC : IDLE) :
                       (state == EXEC) ? RESP : (done ? IDLE : RESP);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_op       <= '0;
            lat_id       <= 1'b0;
            res          <= '0;
            o_grant_cnt0 <= '0;
            o_grant_cnt1 <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_a  <= o_req1_ready ? i_req1_op_a : i_req0_op_a;
                lat_b  <= o_req1_ready ? i_req1_op_b : i_req0_op_b;
                lat_op <= o_req1_ready ? i_req1_alu_op : i_req0_alu_op;
                lat_id <= o_req1_ready;
            end
            if (state == EXEC) res <= alu_data;
            if (o_req0_ready && o_grant_cnt0 != '1) o_grant_cnt0 <= o_grant_cnt0 + CNT_W'(1);
            if (o_req1_ready && o_grant_cnt1 != '1) o_grant_cnt1 <= o_grant_cnt1 + CNT_W'(1);
        end
    end
endmodule
